axi4_lite_burst_master: RTL and testbench
=========================================

# axi4_lite_burst_master

AXI4 master front-end converting a single-outstanding CPU/cache memory request into AXI4 read bursts or single-beat writes. Sits between the LSU/I-cache refill logic and the 64-bit AXI4 fabric, and drives the simulation SRAM slave. One transaction is in flight at a time; read beats and write responses return on a shared response channel with backpressure.

## Interface
Parameters:
- ID, default 4'h0: value driven on arid/awid/wid.
- ADDR_W, default 32: AXI address width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- req_valid / req_ready  in / out  1  request handshake
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_len  in  8  read beats minus 1; ignored for writes
- req_size  in  3  log2 bytes per beat (0..3)
- req_wdata  in  64  write data
- req_wstrb  in  8  write byte strobes
- resp_valid / resp_ready  out / in  1  response handshake
- resp_data  out  64  read beat data; 0 for write responses
- resp_last  out  1  final response of the transaction
- resp_err  out  1  rresp/bresp non-OKAY or beat-count mismatch
- AXI AR: arid[3:0], araddr[ADDR_W], arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0], arvalid out; arready in
- AXI R: rid[3:0], rdata[63:0], rresp[1:0], rlast, rvalid in; rready out
- AXI AW: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid out; awready in
- AXI W: wid, wdata[63:0], wstrb[7:0], wlast, wvalid out; wready in
- AXI B: bid[3:0], bresp[1:0], bvalid in; bready out

## Operation
- FSM states: IDLE, AR, R, WR (AW+W), B.
- IDLE: req_ready=1. On req_valid, latch all req fields. Read goes to AR; write goes to WR.
- AR: arvalid=1 with latched araddr/arlen/arsize and arburst=2'b01 (INCR). On arready, go to R.
- R: rready=resp_ready, and resp_* is combinationally driven from rdata/rlast.
  - Beat counter counts handshakes (rvalid & rready).
  - resp_err = rresp!=0, or (rlast and count!=arlen), or (count==arlen and !rlast).
  - On a handshake with rlast, return to IDLE.
- WR: awvalid and wvalid are both asserted. Each is dropped independently after its own handshake. awlen=0, wlast=1, awburst=INCR. Go to B once both handshakes have occurred, in the same cycle or different cycles.
- B: bready=resp_ready; resp_valid=bvalid, resp_last=1, resp_data=0, resp_err=bresp!=0. On handshake, return to IDLE.
- Constant fields: arlock/awlock=0, arcache/awcache=0, arprot/awprot=0, ids=ID. Returned rid/bid are ignored.
- Reset value of every output: 0, except req_ready=1 (IDLE).

## Timing
- Request accepted at edge N → arvalid or awvalid/wvalid high at N+1. AR/AW/W outputs are registered.
- Valids stay asserted and payloads stay stable until handshake (AXI rule); no combinational path from arready/awready/wready to valids.
- Read latency through the block for R beats is 0 cycles (pass-through). Back-to-back beats are sustained at 1 per cycle.
- After the final R or B handshake at edge M, req_ready=1 in cycle M+1. Minimum turnaround: read 1 + slave latency + beats; write 1 + slave + 1.
- req_valid is ignored outside IDLE. New request fields are never sampled mid-transaction.
- aresetn low mid-transaction: all valids/readies drop at the next edge and the FSM returns to IDLE. Outstanding slave beats are discarded.

## Structure
- Shared package `axi_pkg`: burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/EXOKAY/SLVERR/DECERR), FSM state enum, AXI data/strb widths.
- Single module; no sub-module is needed. Beat counter and FSM live inline.

## Test plan
- Read single: req addr=0x8000_0000, len=0, size=3 → arvalid next cycle with arlen=0, arsize=3, arburst=1; slave rdata=0x1122334455667788, rlast=1 → one resp, last=1, err=0; req_ready high the following cycle.
- Read burst with backpressure: len=3 at 0x8000_0040; resp_ready toggles 1,0,1,1,0,1 → exactly 4 resp beats in order, resp_last only on the 4th, rready mirrors resp_ready.
- Write with skewed handshakes: addr=0x8000_0100, wdata=0xDEADBEEF_CAFEF00D, wstrb=0x0F; awready 2 cycles before wready → awvalid drops first, wvalid held until wready; single resp with last=1, data=0.
- Error paths: rresp=SLVERR on beat 1 of 2 → err=1 on that beat only. bresp=DECERR → err=1. Early rlast on beat 2 of 4 → err=1 and return to IDLE.
- Reset mid-burst: aresetn low during beat 2 of 4 → all outputs at reset values next edge, req_ready=1, a new read then completes normally.
- Idle ignoring: req_valid held during an active read with different addr → no second AR until the first transaction completes.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings, bus widths and the burst master's FSM state type.
package axi_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4
  } state_e;

endpackage

// File: rtl/axi4_lite_burst_master.sv
// Single-outstanding request front-end: reads become INCR bursts, writes become
// single-beat AW+W; R beats and B responses share one response channel.
module axi4_lite_burst_master
  import axi_pkg::*;
#(
  parameter logic [3:0] ID     = 4'h0,
  parameter int         ADDR_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [7:0]            req_len,
  input  logic [2:0]            req_size,
  input  logic [AXI_DATA_W-1:0] req_wdata,
  input  logic [AXI_STRB_W-1:0] req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [AXI_DATA_W-1:0] resp_data,
  output logic                  resp_last,
  output logic                  resp_err,
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [AXI_DATA_W-1:0] wdata,
  output logic [AXI_STRB_W-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  state_e                  state_r, state_s;
  logic [ADDR_W-1:0]       addr_r;
  logic [7:0]              len_r;
  logic [2:0]              size_r;
  logic [AXI_DATA_W-1:0]   wdata_r;
  logic [AXI_STRB_W-1:0]   wstrb_r;
  logic                    arvalid_r, awvalid_r, wvalid_r;
  logic [7:0]              beat_cnt_r;
  logic                    req_fire_s, r_fire_s;
  logic                    unused_s;

  // Returned IDs are not checked: only one transaction is ever outstanding.
  assign unused_s   = ^{rid, bid};
  assign req_fire_s = req_valid && (state_r == ST_IDLE);
  assign r_fire_s   = (state_r == ST_R) && rvalid && resp_ready;

  // State register, request latch, registered AXI valids and the R beat counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      len_r      <= 8'd0;
      size_r     <= 3'd0;
      wdata_r    <= '0;
      wstrb_r    <= '0;
      arvalid_r  <= 1'b0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      beat_cnt_r <= 8'd0;
    end else begin
      state_r <= state_s;
      if (req_fire_s) begin
        addr_r     <= req_addr;
        len_r      <= req_len;
        size_r     <= req_size;
        wdata_r    <= req_wdata;
        wstrb_r    <= req_wstrb;
        arvalid_r  <= !req_wr;
        awvalid_r  <= req_wr;
        wvalid_r   <= req_wr;
        beat_cnt_r <= 8'd0;
      end else begin
        // Each channel's valid falls on its own handshake, independently.
        if (arvalid_r && arready) arvalid_r <= 1'b0;
        if (awvalid_r && awready) awvalid_r <= 1'b0;
        if (wvalid_r && wready)   wvalid_r  <= 1'b0;
        if (r_fire_s)             beat_cnt_r <= beat_cnt_r + 8'd1;
      end
    end
  end

  // Next-state logic and the pass-through response channel.
  always_comb begin
    state_s    = state_r;
    req_ready  = 1'b0;
    rready     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_last  = 1'b0;
    resp_err   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_s = req_wr ? ST_WR : ST_AR;
        else           state_s = ST_IDLE;
      end
      ST_AR: begin
        if (arready) state_s = ST_R;
        else         state_s = ST_AR;
      end
      ST_R: begin
        rready     = resp_ready;
        resp_valid = rvalid;
        resp_data  = rdata;
        resp_last  = rlast;
        resp_err   = (rresp != RESP_OKAY) ||
                     (rlast && (beat_cnt_r != len_r)) ||
                     ((beat_cnt_r == len_r) && !rlast);
        if (rvalid && resp_ready && rlast) state_s = ST_IDLE;
        else                               state_s = ST_R;
      end
      ST_WR: begin
        if ((!awvalid_r || awready) && (!wvalid_r || wready)) state_s = ST_B;
        else                                                   state_s = ST_WR;
      end
      ST_B: begin
        bready     = resp_ready;
        resp_valid = bvalid;
        resp_last  = 1'b1;
        resp_err   = (bresp != RESP_OKAY);
        if (bvalid && resp_ready) state_s = ST_IDLE;
        else                      state_s = ST_B;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Burst type and wlast follow the registered valids so every output is 0 in reset.
  assign arid    = ID;
  assign araddr  = addr_r;
  assign arlen   = len_r;
  assign arsize  = size_r;
  assign arburst = arvalid_r ? BURST_INCR : BURST_FIXED;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_r;

  assign awid    = ID;
  assign awaddr  = addr_r;
  assign awlen   = 8'd0;
  assign awsize  = size_r;
  assign awburst = awvalid_r ? BURST_INCR : BURST_FIXED;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_r;

  assign wid     = ID;
  assign wdata   = wdata_r;
  assign wstrb   = wstrb_r;
  assign wlast   = wvalid_r;
  assign wvalid  = wvalid_r;

endmodule

// File: tb/tb_axi4_lite_burst_master.sv
// Directed bench for axi4_lite_burst_master: the stimulus thread pushes expected
// responses into a scoreboard queue, a negedge monitor pops them on each handshake.
module tb_axi4_lite_burst_master;
  import axi_pkg::*;

  logic        aclk, aresetn;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_last, resp_err;
  logic [63:0] resp_data;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] rdata, wdata;
  logic [7:0]  wstrb;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  axi4_lite_burst_master #(.ID(4'h0), .ADDR_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic l, input logic e);
    exp_t x;
    x.data = d; x.last = l; x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [63:0] wd, input logic [7:0] ws);
    req_wr = wr; req_addr = addr; req_len = len; req_size = size;
    req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic ar_handshake();
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("arvalid_dropped", 64'(arvalid), 64'd0);
  endtask

  task automatic drive_r(input logic [63:0] d, input logic l, input logic [1:0] rs,
                         input logic rr);
    rvalid = 1'b1; rdata = d; rlast = l; rresp = rs; resp_ready = rr;
    #1;
    chk("rready_mirror", 64'(rready), 64'(rr));
  endtask

  // Scoreboard monitor: every response handshake must match the queue head.
  always @(negedge aclk) begin
    if (aresetn && resp_valid && resp_ready) begin
      chk("resp_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("resp_data", resp_data, mon_e.data);
        chk("resp_last", 64'(resp_last), 64'(mon_e.last));
        chk("resp_err", 64'(resp_err), 64'(mon_e.err));
      end
    end
  end

  initial begin
    logic pat [6];
    int   b;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    aresetn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'd0; req_len = 8'd0;
    req_size = 3'd0; req_wdata = 64'd0; req_wstrb = 8'd0; resp_ready = 1'b0;
    arready = 1'b0; rid = 4'd0; rdata = 64'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'b00; bvalid = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready, resp_valid}), 64'd0);
    chk("rst_payload", 64'({araddr, arlen, arsize, arburst, awburst, wlast}), 64'd0);
    aresetn = 1'b1;
    step();

    // Single-beat read
    issue(1'b0, 32'h8000_0000, 8'd0, 3'd3, 64'd0, 8'd0);
    chk("rd1_arvalid", 64'(arvalid), 64'd1);
    chk("rd1_araddr", 64'(araddr), 64'h8000_0000);
    chk("rd1_arlen_size_burst", 64'({arlen, arsize, arburst}), 64'({8'd0, 3'd3, 2'b01}));
    chk("rd1_no_aw", 64'({awvalid, wvalid}), 64'd0);
    chk("rd1_req_ready_busy", 64'(req_ready), 64'd0);
    push(64'h1122_3344_5566_7788, 1'b1, 1'b0);
    ar_handshake();
    drive_r(64'h1122_3344_5566_7788, 1'b1, RESP_OKAY, 1'b1);
    step();
    rvalid = 1'b0;
    chk("rd1_req_ready_after", 64'(req_ready), 64'd1);

    // Four-beat burst with response backpressure
    issue(1'b0, 32'h8000_0040, 8'd3, 3'd3, 64'd0, 8'd0);
    chk("rd4_araddr", 64'(araddr), 64'h8000_0040);
    chk("rd4_arlen", 64'(arlen), 64'd3);
    for (int i = 0; i < 4; i++) push(64'h0000_0000_0000_0A00 + 64'(i), i == 3, 1'b0);
    ar_handshake();
    b = 0;
    for (int i = 0; i < 6; i++) begin
      drive_r(64'h0000_0000_0000_0A00 + 64'(b), b == 3, RESP_OKAY, pat[i]);
      step();
      if (pat[i]) b++;
    end
    rvalid = 1'b0; resp_ready = 1'b0;
    chk("rd4_req_ready_after", 64'(req_ready), 64'd1);

    // Write with AW accepted two cycles before W
    issue(1'b1, 32'h8000_0100, 8'hFF, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
    chk("wr_valids", 64'({awvalid, wvalid, arvalid}), 64'b110);
    chk("wr_awaddr", 64'(awaddr), 64'h8000_0100);
    chk("wr_awlen_burst", 64'({awlen, awburst}), 64'({8'd0, 2'b01}));
    chk("wr_wdata", wdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("wr_wstrb_wlast", 64'({wstrb, wlast}), 64'({8'h0F, 1'b1}));
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("wr_aw_first", 64'({awvalid, wvalid}), 64'b01);
    step();
    chk("wr_w_held", 64'({awvalid, wvalid}), 64'b01);
    wready = 1'b1;
    step();
    wready = 1'b0;
    chk("wr_w_dropped", 64'(wvalid), 64'd0);
    push(64'd0, 1'b1, 1'b0);
    bvalid = 1'b1; bresp = RESP_OKAY; resp_ready = 1'b1;
    #1;
    chk("wr_bready", 64'(bready), 64'd1);
    step();
    bvalid = 1'b0;
    chk("wr_req_ready_after", 64'(req_ready), 64'd1);

    // SLVERR on the first of two beats
    issue(1'b0, 32'h8000_0200, 8'd1, 3'd3, 64'd0, 8'd0);
    push(64'h0000_0000_0000_0B00, 1'b0, 1'b1);
    push(64'h0000_0000_0000_0B01, 1'b1, 1'b0);
    ar_handshake();
    drive_r(64'h0000_0000_0000_0B00, 1'b0, RESP_SLVERR, 1'b1);
    step();
    drive_r(64'h0000_0000_0000_0B01, 1'b1, RESP_OKAY, 1'b1);
    step();
    rvalid = 1'b0;

    // DECERR write, AW and W accepted in the same cycle
    issue(1'b1, 32'h8000_0180, 8'd0, 3'd2, 64'h0123_4567_89AB_CDEF, 8'hF0);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    chk("wr2_both_dropped", 64'({awvalid, wvalid}), 64'd0);
    push(64'd0, 1'b1, 1'b1);
    bvalid = 1'b1; bresp = RESP_DECERR;
    step();
    bvalid = 1'b0; bresp = RESP_OKAY;
    chk("wr2_req_ready_after", 64'(req_ready), 64'd1);

    // Early rlast on beat 2 of 4
    issue(1'b0, 32'h8000_0280, 8'd3, 3'd3, 64'd0, 8'd0);
    push(64'h0000_0000_0000_0C00, 1'b0, 1'b0);
    push(64'h0000_0000_0000_0C01, 1'b1, 1'b1);
    ar_handshake();
    drive_r(64'h0000_0000_0000_0C00, 1'b0, RESP_OKAY, 1'b1);
    step();
    drive_r(64'h0000_0000_0000_0C01, 1'b1, RESP_OKAY, 1'b1);
    step();
    rvalid = 1'b0; rlast = 1'b0;
    chk("early_last_idle", 64'(req_ready), 64'd1);

    // Reset asserted while beat 2 of 4 is pending
    issue(1'b0, 32'h8000_0300, 8'd3, 3'd3, 64'd0, 8'd0);
    push(64'h0000_0000_0000_0D00, 1'b0, 1'b0);
    ar_handshake();
    drive_r(64'h0000_0000_0000_0D00, 1'b0, RESP_OKAY, 1'b1);
    step();
    drive_r(64'h0000_0000_0000_0D01, 1'b0, RESP_OKAY, 1'b0);
    aresetn = 1'b0;
    step();
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready, resp_valid}), 64'd0);
    aresetn = 1'b1; rvalid = 1'b0; resp_ready = 1'b1;
    step();
    issue(1'b0, 32'h8000_0400, 8'd0, 3'd3, 64'd0, 8'd0);
    chk("post_rst_araddr", 64'(araddr), 64'h8000_0400);
    push(64'h0000_0000_0000_0E00, 1'b1, 1'b0);
    ar_handshake();
    drive_r(64'h0000_0000_0000_0E00, 1'b1, RESP_OKAY, 1'b1);
    step();
    rvalid = 1'b0;
    chk("post_rst_idle", 64'(req_ready), 64'd1);

    // req_valid held through a read with changing request fields
    req_wr = 1'b0; req_addr = 32'h8000_0500; req_len = 8'd1; req_size = 3'd3;
    req_valid = 1'b1;
    step();
    req_addr = 32'h8000_0600; req_len = 8'd0;
    chk("hold_araddr", 64'(araddr), 64'h8000_0500);
    chk("hold_arlen", 64'(arlen), 64'd1);
    push(64'h0000_0000_0000_0F00, 1'b0, 1'b0);
    push(64'h0000_0000_0000_0F01, 1'b1, 1'b0);
    ar_handshake();
    step();
    chk("hold_no_second_ar", 64'({arvalid, req_ready}), 64'd0);
    drive_r(64'h0000_0000_0000_0F00, 1'b0, RESP_OKAY, 1'b1);
    step();
    drive_r(64'h0000_0000_0000_0F01, 1'b1, RESP_OKAY, 1'b1);
    step();
    rvalid = 1'b0;
    chk("hold_idle_after", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    chk("hold_second_ar", 64'(arvalid), 64'd1);
    chk("hold_second_araddr", 64'(araddr), 64'h8000_0600);
    chk("hold_second_arlen", 64'(arlen), 64'd0);
    push(64'h0000_0000_0000_0F10, 1'b1, 1'b0);
    ar_handshake();
    drive_r(64'h0000_0000_0000_0F10, 1'b1, RESP_OKAY, 1'b1);
    step();
    rvalid = 1'b0;
    step();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
